// File: rtl/onchip_ram_bist_pkg.sv
// Shared types and constants for the on-chip RAM BIST master.
// Imported by the sequencer top and the compare checker.
package onchip_ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        FIN
    } state_t;

    localparam logic [1:0] MODE_FILL        = 2'd0;
    localparam logic [1:0] MODE_VERIFY      = 2'd1;
    localparam logic [1:0] MODE_FILL_VERIFY = 2'd2;
    localparam logic [1:0] MODE_NOP         = 2'd3;

    localparam int unsigned READ_LATENCY = 1;

endpackage

// File: rtl/onchip_ram_bist_checker.sv
// One-deep read compare pipe with saturating error count
// and first-mismatch address capture.
module onchip_ram_bist_checker
    import onchip_ram_bist_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] readdata,
    output logic              error,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic              pipe_v;
    logic [DATA_W-1:0] pipe_exp;
    logic [ADDR_W-1:0] pipe_addr;
    logic              miss;

    assign miss = pipe_v && (readdata != pipe_exp);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pipe_v         <= 1'b0;
            pipe_exp       <= '0;
            pipe_addr      <= '0;
            error          <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            pipe_v    <= rd_valid;
            pipe_exp  <= rd_exp;
            pipe_addr <= rd_addr;
            if (miss) begin
                error <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
                // sticky error doubles as "first mismatch already seen"
                if (!error)
                    first_err_addr <= pipe_addr;
            end
        end
    end

endmodule

// File: rtl/onchip_ram_bist_master.sv
// Avalon-MM fill/verify sequencer for the on-chip RAM slave.
// One word per cycle; all bus and status outputs are registered.
module onchip_ram_bist_master
    import onchip_ram_bist_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] address,
    output logic [BE_W-1:0]   byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata
);

    localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

    state_t            state;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] seed_q;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  nidx;
    logic [LEN_W-1:0]  len_eff;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_data;
    logic              last;
    logic              clr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_exp;

    assign len_eff  = (32'(length) > MAX_LEN) ? LEN_W'(MAX_LEN) : length;
    assign nidx     = idx + 1'b1;
    assign nxt_addr = base_q + nidx[ADDR_W-1:0];
    assign nxt_data = seed_q + DATA_W'(nidx);
    assign last     = (idx == len_q - 1'b1);
    assign clr      = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= '0;
            len_q      <= '0;
            base_q     <= '0;
            seed_q     <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            clken      <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            address    <= '0;
            writedata  <= '0;
            rd_valid   <= 1'b0;
            rd_exp     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    mode_q <= mode;
                    len_q  <= len_eff;
                    base_q <= base_addr;
                    seed_q <= seed;
                    idx    <= '0;
                    if (mode == MODE_NOP || len_eff == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        busy       <= 1'b1;
                        clken      <= 1'b1;
                        chipselect <= 1'b1;
                        byteenable <= '1;
                        address    <= base_addr;
                        if (mode == MODE_VERIFY) begin
                            state    <= READ;
                            rd_valid <= 1'b1;
                            rd_exp   <= seed;
                        end else begin
                            state     <= WRITE;
                            write     <= 1'b1;
                            writedata <= seed;
                        end
                    end
                end
                WRITE: if (!last) begin
                    idx       <= nidx;
                    address   <= nxt_addr;
                    writedata <= nxt_data;
                end else if (mode_q == MODE_FILL_VERIFY) begin
                    state     <= READ;
                    idx       <= '0;
                    address   <= base_q;
                    write     <= 1'b0;
                    writedata <= '0;
                    rd_valid  <= 1'b1;
                    rd_exp    <= seed_q;
                end else begin
                    state      <= FIN;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    clken      <= 1'b0;
                    chipselect <= 1'b0;
                    write      <= 1'b0;
                    byteenable <= '0;
                    address    <= '0;
                    writedata  <= '0;
                end
                READ: if (!last) begin
                    idx      <= nidx;
                    address  <= nxt_addr;
                    rd_exp   <= nxt_data;
                end else begin
                    state      <= DRAIN;
                    chipselect <= 1'b0;
                    byteenable <= '0;
                    address    <= '0;
                    rd_valid   <= 1'b0;
                    rd_exp     <= '0;
                end
                DRAIN: begin
                    state <= FIN;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    clken <= 1'b0;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    onchip_ram_bist_checker #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .rd_valid      (rd_valid),
        .rd_exp        (rd_exp),
        .rd_addr       (address),
        .readdata      (readdata),
        .error         (error),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
    );

endmodule

// File: tb/tb_onchip_ram_bist_master.sv
// Randomized bench for onchip_ram_bist_master against an
// ideal 1-cycle-latency RAM and a word-level reference model.
module tb_onchip_ram_bist_master;
    import onchip_ram_bist_pkg::*;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int CW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, error, chipselect, write, clken;
    logic [CW-1:0] err_count;
    logic [AW-1:0] first_err_addr, address;
    logic [3:0]    byteenable;
    logic [DW-1:0] writedata, readdata;

    always #5 clk = ~clk;

    onchip_ram_bist_master dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed),
        .busy(busy), .done(done), .error(error),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .write(write),
        .writedata(writedata), .clken(clken), .readdata(readdata)
    );

    // pmem/pgen belong to the stimulus process, wmem/wgen to the slave
    logic [DW-1:0] pmem    [DEPTH];
    logic [DW-1:0] wmem    [DEPTH];
    int            wgen    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int            pgen = 1;
    logic [AW-1:0] addr_q = '0;

    always @(posedge clk) begin
        if (chipselect) begin
            addr_q <= address;
            if (write) begin
                wmem[address] <= writedata;
                wgen[address] <= pgen;
            end
        end
    end

    assign readdata = (wgen[addr_q] == pgen) ? wmem[addr_q] : pmem[addr_q];

    function automatic logic [DW-1:0] eff(input logic [AW-1:0] a);
        return (wgen[a] == pgen) ? wmem[a] : pmem[a];
    endfunction

    int wr_n = 0, rd_n = 0, bus_bad = 0, done_n = 0;

    always @(negedge clk) begin
        if (chipselect && write) wr_n++;
        if (chipselect && !write) rd_n++;
        if (!chipselect && (address != '0 || writedata != '0 || write)) bus_bad++;
        if (chipselect && byteenable != 4'hF) bus_bad++;
        if (busy && !clken) bus_bad++;
        if (done) done_n++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic commit();
        pgen++;
        for (int a = 0; a < DEPTH; a++) pmem[a] = ref_mem[a];
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".cs"}, chipselect, 0);
        chk({tag, ".clken"}, clken, 0);
        chk({tag, ".bus"}, {write, byteenable, address, writedata}, 0);
        chk({tag, ".stat"}, {error, err_count, first_err_addr}, 0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [AW-1:0] b,
                          input logic [LW-1:0] l, input logic [DW-1:0] s);
        int effl, exp_cyc, exp_cnt, exp_wr, exp_rd, c, nb, bad;
        int w0, r0, bb0, d0;
        logic exp_err;
        logic [AW-1:0] exp_fea, a;
        bit fill, ver;
        effl = (int'(l) > DEPTH) ? DEPTH : int'(l);
        if (m == MODE_NOP) effl = 0;
        fill = (m == MODE_FILL) || (m == MODE_FILL_VERIFY);
        ver  = (m == MODE_VERIFY) || (m == MODE_FILL_VERIFY);
        commit();
        exp_err = 1'b0; exp_cnt = 0; exp_fea = '0;
        if (fill)
            for (int i = 0; i < effl; i++) ref_mem[b + AW'(i)] = s + DW'(i);
        if (ver)
            for (int i = 0; i < effl; i++) begin
                a = b + AW'(i);
                if (ref_mem[a] != s + DW'(i)) begin
                    if (!exp_err) exp_fea = a;
                    exp_err = 1'b1;
                    if (exp_cnt < 65535) exp_cnt++;
                end
            end
        exp_wr  = fill ? effl : 0;
        exp_rd  = ver ? effl : 0;
        exp_cyc = (effl == 0) ? 1 : exp_wr + exp_rd + (ver ? 2 : 1);

        @(negedge clk);
        mode = m; base_addr = b; length = l; seed = s; start = 1'b1;
        w0 = wr_n; r0 = rd_n; bb0 = bus_bad; d0 = done_n;
        c = 0; nb = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (!done && !busy) nb++;
        end while (!done && c < 70000);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".cyc"}, c, exp_cyc);
        chk({tag, ".busylo"}, nb, 0);
        chk({tag, ".busy@done"}, busy, 0);
        chk({tag, ".err"}, error, exp_err);
        chk({tag, ".cnt"}, err_count, exp_cnt);
        chk({tag, ".fea"}, first_err_addr, exp_fea);
        @(negedge clk);
        chk({tag, ".pulse"}, done, 0);
        chk({tag, ".hold"}, {error, err_count, first_err_addr}, {exp_err, CW'(exp_cnt), exp_fea});
        chk({tag, ".nwr"}, wr_n - w0, exp_wr);
        chk({tag, ".nrd"}, rd_n - r0, exp_rd);
        chk({tag, ".bus"}, bus_bad - bb0, 0);
        chk({tag, ".ndone"}, done_n - d0, 1);
        if (fill) begin
            bad = 0;
            for (int i = 0; i < effl; i++)
                if (eff(b + AW'(i)) !== ref_mem[b + AW'(i)]) bad++;
            chk({tag, ".image"}, bad, 0);
        end
    endtask

    initial begin
        int d0;
        logic [1:0]    m;
        logic [AW-1:0] b;
        logic [LW-1:0] l;
        logic [DW-1:0] s;

        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        chk_zero("idle");

        run_op("fv8", MODE_FILL_VERIFY, 15'h0, 16'd8, 32'h1000);
        chk("fv8.w0", eff(15'h0), 32'h1000);
        chk("fv8.w7", eff(15'h7), 32'h1007);

        for (int i = 0; i < 4; i++) ref_mem[15'h10 + AW'(i)] = DW'(i);
        ref_mem[15'h12] = 32'hFFFF;
        run_op("vbad", MODE_VERIFY, 15'h10, 16'd4, 32'h0);

        run_op("wrap", MODE_FILL, 15'h7FFF, 16'd2, 32'd5);
        chk("wrap.hi", eff(15'h7FFF), 32'd5);
        chk("wrap.lo", eff(15'h0000), 32'd6);

        run_op("len0", MODE_FILL_VERIFY, 15'h123, 16'd0, 32'h77);
        run_op("nop", MODE_NOP, 15'h40, 16'd5, 32'h9);

        @(negedge clk);
        mode = MODE_FILL; base_addr = 15'h100; length = 16'd16; seed = 32'hA0; start = 1'b1;
        @(negedge clk);
        mode = MODE_VERIFY; base_addr = 15'h2000; seed = 32'h5555;
        chk("abort.c1", {busy, write, address, writedata}, {1'b1, 1'b1, 15'h100, 32'hA0});
        @(negedge clk);
        start = 1'b0;
        chk("abort.c2", {busy, write, address, writedata}, {1'b1, 1'b1, 15'h101, 32'hA1});
        @(negedge clk);
        reset = 1'b1;
        d0 = done_n;
        @(negedge clk);
        chk_zero("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort.nodone", done_n - d0, 0);
        chk("abort.idle", {busy, chipselect}, 0);

        for (int k = 0; k < 20; k++) begin
            m = 2'($urandom_range(0, 3));
            b = AW'($urandom);
            l = LW'($urandom_range(0, 40));
            s = $urandom;
            for (int i = 0; i < int'(l); i++)
                ref_mem[b + AW'(i)] = ($urandom_range(0, 3) == 0) ? $urandom : s + DW'(i);
            run_op($sformatf("rnd%0d", k), m, b, l, s);
        end

        b = 15'h1234;
        s = 32'hCAFE0000;
        for (int i = 0; i < DEPTH; i++) ref_mem[b + AW'(i)] = ~(s + DW'(i));
        run_op("clamp", MODE_VERIFY, b, 16'hFFFF, s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
